rna_seq_ctrl: RTL and testbench
===============================

RNA_SEQ_CTRL -- requirements
Module: rna_seq_ctrl

Interface
REQ-001 SHALL have parameter IN_W, 19, signed sample width to the datapath.
REQ-002 SHALL have parameter OUT_W, 28, signed result width from the datapath.
REQ-003 SHALL have parameter FIFO_DEPTH, 8, input sample FIFO depth (power of two, minimum 2).
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  one-cycle run request, honoured only in IDLE.
REQ-007 SHALL have port n_samples  input  16  samples per run, sampled on an accepted start.
REQ-008 SHALL have port s_data  input  IN_W  upstream sample (signed).
REQ-009 SHALL have port s_valid  input  1  upstream sample valid.
REQ-010 SHALL have port s_ready  output  1  FIFO can accept a sample.
REQ-011 SHALL have port dp_req  input  4  datapath request code; 4'd1 = next sample wanted.
REQ-012 SHALL have port dp_in  output  IN_W  registered sample to the datapath.
REQ-013 SHALL have port dp_en  output  1  datapath clock enable; 0 freezes the datapath, which holds dp_req stable while frozen.
REQ-014 SHALL have port dp_out_en  input  4  datapath output code; 4'd1 = dp_out valid.
REQ-015 SHALL have port dp_out  input  OUT_W  datapath result (signed).
REQ-016 SHALL have port m_data  output  OUT_W  forwarded result; m_valid  output  1  one-cycle strobe for it.
REQ-017 SHALL have port busy  output  1, done  output  1, stall_cnt  output  16.

Function
REQ-018 SHALL implement the states IDLE, RUN, DRAIN and DONE.
REQ-019 SHALL, in IDLE on start=1, latch n_samples, clear the issued and collected counters, and go to RUN; if n_samples=0, it SHALL go directly to DONE.
REQ-020 SHALL ignore start in any state other than IDLE.
REQ-021 SHALL push s_data when s_valid=1 and s_ready=1, with s_ready = !full computed from the registered count; a pop that frees space SHALL NOT enable a same-cycle push.
REQ-022 SHALL pop in RUN when dp_req=4'd1, dp_en=1, the FIFO is not empty and issued<n_samples; dp_in SHALL take the head value the next cycle and issued SHALL increment.
REQ-023 SHALL drive dp_en=0 in RUN when dp_req=4'd1, the FIFO is empty and issued<n_samples (underrun stall); otherwise dp_en=1 in RUN and DRAIN, and dp_en=0 in IDLE and DONE.
REQ-024 SHALL not let a push into an empty FIFO be popped in the same cycle; the stall releases one cycle after the push.
REQ-025 SHALL go from RUN to DRAIN when issued=n_samples.
REQ-026 SHALL, in DRAIN, answer dp_req=4'd1 by loading dp_in=0 without popping and without counting.
REQ-027 SHALL, when dp_out_en=4'd1 and dp_en=1 in RUN or DRAIN, register m_data<=dp_out and pulse m_valid=1 for one cycle (1-cycle latency) and increment collected.
REQ-028 SHALL go from RUN or DRAIN to DONE when collected reaches n_samples.
REQ-029 SHALL keep DONE for one cycle with done=1, then return to IDLE.
REQ-030 SHALL drive busy=1 in every state except IDLE.
REQ-031 SHALL retain leftover FIFO samples across runs.
REQ-032 SHALL treat dp_req or dp_out_en codes other than 4'd1 as no action.

Reset
REQ-033 SHALL, while rst=1, force state=IDLE, flush the FIFO, and drive s_ready=0, dp_in=0, dp_en=0, m_data=0, m_valid=0, busy=0, done=0, stall_cnt=0 and counters=0.
REQ-034 SHALL, when rst is asserted mid-run, abort the run immediately with no done pulse, and s_ready SHALL return to 1 in the first cycle after rst falls.

Configuration
REQ-035 SHALL, with RNA_SEQ_STATS_EN defined, make stall_cnt count cycles with dp_en=0 in RUN, saturating at 16'hFFFF and cleared on an accepted start; without RNA_SEQ_STATS_EN, stall_cnt SHALL be tied to 0 with no counter logic.

Verification
REQ-036 SHALL be verified by: 4 samples preloaded (10, -3, 262143, -262144), start with n_samples=4, datapath requesting every 4 cycles -> dp_in follows the sequence, no stall, 4 m_valid pulses, done one cycle after the 4th result.
REQ-037 SHALL be verified by: empty FIFO, start with n_samples=2, request pending, push 7 after 5 cycles -> dp_en=0 for 6 cycles, dp_in=7, stall_cnt=6 (with the macro) or 0 (without it).
REQ-038 SHALL be verified by: 8 pushes while the FIFO is full, with a simultaneous pop on cycle 9 -> s_ready=0 on cycle 9, no push accepted, s_ready=1 on cycle 10.
REQ-039 SHALL be verified by: n_samples=2 with the datapath requesting 3 times before 2 results -> 3rd dp_in=0, FIFO count unchanged, done after 2nd dp_out_en=4'd1.
REQ-040 SHALL be verified by: rst pulsed mid-RUN with 3 samples queued -> all outputs at reset values, FIFO empty, no done pulse; start with n_samples=0 -> done next cycle.

Source files
------------

// File: rtl/rna_seq_ctrl.sv
// Run sequencer between an upstream sample FIFO and a stallable datapath.
// Define RNA_SEQ_STATS_EN to build the underrun stall-cycle counter on stall_cnt.
module rna_seq_ctrl #(
  parameter int IN_W       = 19,
  parameter int OUT_W      = 28,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      n_samples,
  input  logic [IN_W-1:0]  s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [3:0]       dp_req,
  output logic [IN_W-1:0]  dp_in,
  output logic             dp_en,
  input  logic [3:0]       dp_out_en,
  input  logic [OUT_W-1:0] dp_out,
  output logic [OUT_W-1:0] m_data,
  output logic             m_valid,
  output logic             busy,
  output logic             done,
  output logic [15:0]      stall_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state, state_nxt;
  logic [IN_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [15:0]     n_lat, issued, collected;
  logic            full, empty, req, out_req, more, all_collected;
  logic            push, pop, drain_load, collect, accept_start;

  assign full          = (count == CW'(FIFO_DEPTH));
  assign empty         = (count == '0);
  assign req           = (dp_req == 4'd1);
  assign out_req       = (dp_out_en == 4'd1);
  assign more          = (issued < n_lat);
  assign all_collected = (collected == n_lat);

  // Readiness and emptiness come from the registered count, so a push is never popped in its own cycle.
  always_comb begin
    state_nxt    = state;
    s_ready      = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    dp_en        = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    drain_load   = 1'b0;
    collect      = 1'b0;
    accept_start = 1'b0;
    if (!rst) begin
      s_ready = !full;
      push    = s_valid && !full;
      busy    = (state != IDLE);
      done    = (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            accept_start = 1'b1;
            state_nxt    = (n_samples == 16'd0) ? DONE : RUN;
          end
        end
        RUN: begin
          dp_en      = !(req && empty && more);
          pop        = req && !empty && more;
          drain_load = req && !more;
          collect    = out_req && dp_en && !all_collected;
          if (all_collected)
            state_nxt = DONE;
          else if (!more)
            state_nxt = DRAIN;
        end
        DRAIN: begin
          dp_en      = 1'b1;
          drain_load = req;
          collect    = out_req && !all_collected;
          if (all_collected)
            state_nxt = DONE;
        end
        DONE: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Once every sample has been issued, further datapath requests are fed zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_in     <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      n_lat     <= '0;
      issued    <= '0;
      collected <= '0;
    end else begin
      m_valid <= collect;
      if (collect) begin
        m_data    <= dp_out;
        collected <= collected + 16'd1;
      end
      if (pop) begin
        dp_in  <= mem[rd_ptr];
        issued <= issued + 16'd1;
      end else if (drain_load) begin
        dp_in <= '0;
      end
      if (accept_start) begin
        n_lat     <= n_samples;
        issued    <= '0;
        collected <= '0;
      end
    end
  end

`ifdef RNA_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (accept_start)
      stall_cnt <= '0;
    else if (state == RUN && !dp_en && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_rna_seq_ctrl.sv
// Self-checking bench for rna_seq_ctrl: table-driven run plus hand-written corner sequences.
// Sample and result scoreboards are filled as stimulus is driven and drained as the DUT responds.
module tb_rna_seq_ctrl;
  localparam int IN_W  = 19;
  localparam int OUT_W = 28;
  localparam int DEPTH = 8;
`ifdef RNA_SEQ_STATS_EN
  localparam int STALL_EXP = 6;
`else
  localparam int STALL_EXP = 0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [15:0]      n_samples = '0;
  logic [IN_W-1:0]  s_data = '0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [3:0]       dp_req = '0;
  logic [IN_W-1:0]  dp_in;
  logic             dp_en;
  logic [3:0]       dp_out_en = '0;
  logic [OUT_W-1:0] dp_out = '0;
  logic [OUT_W-1:0] m_data;
  logic             m_valid;
  logic             busy;
  logic             done;
  logic [15:0]      stall_cnt;

  rna_seq_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .dp_req(dp_req), .dp_in(dp_in), .dp_en(dp_en),
    .dp_out_en(dp_out_en), .dp_out(dp_out),
    .m_data(m_data), .m_valid(m_valid),
    .busy(busy), .done(done), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IN_W-1:0]  sample;
    logic [OUT_W-1:0] result;
    logic [IN_W-1:0]  exp_dp_in;
    logic [OUT_W-1:0] exp_m_data;
  } vec_t;

  vec_t             vecs [4];
  int               checks = 0;
  int               failures = 0;
  int               done_seen = 0;
  logic [IN_W-1:0]  fifo_q [$];
  logic [OUT_W-1:0] res_q [$];
  int               m_n = 0;
  int               m_issued = 0;
  int               m_collected = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int n);
    start     = 1'b1;
    n_samples = 16'(n);
    step();
    start       = 1'b0;
    m_n         = n;
    m_issued    = 0;
    m_collected = 0;
  endtask

  task automatic applyPush(input logic [IN_W-1:0] val, input string name);
    bit exp_ready;
    exp_ready = (fifo_q.size() < DEPTH);
    s_valid = 1'b1;
    s_data  = val;
    #1;
    checkOutput(name, 32'(s_ready), 32'(exp_ready));
    if (exp_ready)
      fifo_q.push_back(val);
    step();
    s_valid = 1'b0;
  endtask

  task automatic applyRequest(input string name);
    logic [IN_W-1:0] exp;
    bit drain;
    drain  = (m_issued >= m_n);
    dp_req = 4'd1;
    #1;
    checkOutput({name, "_dp_en"}, 32'(dp_en), 32'd1);
    if (drain) begin
      exp = '0;
    end else begin
      exp = fifo_q.pop_front();
      m_issued++;
    end
    step();
    dp_req = 4'd0;
    checkOutput(name, 32'(dp_in), 32'(exp));
  endtask

  task automatic applyResult(input logic [OUT_W-1:0] val);
    dp_out_en = 4'd1;
    dp_out    = val;
    if (m_collected < m_n) begin
      res_q.push_back(val);
      m_collected++;
    end
    step();
    dp_out_en = 4'd0;
  endtask

  // Called right after the edge that registered the final result.
  task automatic checkDoneSeq(input string name);
    checkOutput({name, "_done_early"}, 32'(done), 32'd0);
    step();
    checkOutput({name, "_done"}, 32'(done), 32'd1);
    checkOutput({name, "_busy_done"}, 32'(busy), 32'd1);
    step();
    checkOutput({name, "_done_drop"}, 32'(done), 32'd0);
    checkOutput({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  always @(negedge clk) begin
    if (done === 1'b1)
      done_seen++;
    if (m_valid === 1'b1) begin
      if (res_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL m_valid_unexpected: got m_data=%0h expected no strobe", m_data);
      end else begin
        logic [OUT_W-1:0] e;
        e = res_q.pop_front();
        checkOutput("m_data", 32'(m_data), 32'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int stalls;
    int done_before;

    vecs[0] = '{sample: IN_W'(10),      result: OUT_W'(1000),       exp_dp_in: IN_W'(10),      exp_m_data: OUT_W'(1000)};
    vecs[1] = '{sample: IN_W'(-3),      result: OUT_W'(-5),         exp_dp_in: IN_W'(-3),      exp_m_data: OUT_W'(-5)};
    vecs[2] = '{sample: IN_W'(262143),  result: OUT_W'(134217727),  exp_dp_in: IN_W'(262143),  exp_m_data: OUT_W'(134217727)};
    vecs[3] = '{sample: IN_W'(-262144), result: OUT_W'(-134217728), exp_dp_in: IN_W'(-262144), exp_m_data: OUT_W'(-134217728)};

    // Reset values while rst is held.
    step();
    step();
    checkOutput("rst_s_ready", 32'(s_ready), 32'd0);
    checkOutput("rst_dp_in", 32'(dp_in), 32'd0);
    checkOutput("rst_dp_en", 32'(dp_en), 32'd0);
    checkOutput("rst_m_data", 32'(m_data), 32'd0);
    checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("rst_release_s_ready", 32'(s_ready), 32'd1);
    step();

    // Four preloaded extreme samples, datapath asking every 4 cycles.
    for (int i = 0; i < 4; i++)
      applyPush(vecs[i].sample, "v_push");
    applyStimulus(4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("v_head_model", 32'(fifo_q[0]), 32'(vecs[i].exp_dp_in));
      applyRequest("v_dp_in");
      step();
      applyResult(vecs[i].result);
      checkOutput("v_result_model", 32'(res_q[res_q.size()-1]), 32'(vecs[i].exp_m_data));
      if (i < 3)
        step();
    end
    checkDoneSeq("v");
    checkOutput("v_no_stall", 32'(stall_cnt), 32'd0);

    // Underrun: request pending on an empty FIFO, sample arrives after 5 cycles.
    applyStimulus(2);
    dp_req = 4'd1;
    stalls = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (!dp_en) stalls++;
      step();
    end
    s_valid = 1'b1;
    s_data  = IN_W'(7);
    #1;
    checkOutput("u_push_ready", 32'(s_ready), 32'd1);
    if (!dp_en) stalls++;
    step();
    s_valid = 1'b0;
    #1;
    checkOutput("u_release", 32'(dp_en), 32'd1);
    step();
    dp_req = 4'd0;
    m_issued++;
    checkOutput("u_dp_in", 32'(dp_in), 32'd7);
    checkOutput("u_stall_cycles", 32'(stalls), 32'd6);
    checkOutput("u_stall_cnt", 32'(stall_cnt), 32'(STALL_EXP));
    applyPush(IN_W'(11), "u_push2");
    applyRequest("u_dp_in2");
    applyResult(OUT_W'(77));
    step();
    applyResult(OUT_W'(78));
    checkDoneSeq("u");

    // Drain: three requests for a two-sample run, third gets zero and leaves 22 queued.
    applyPush(IN_W'(20), "d_push");
    applyPush(IN_W'(21), "d_push");
    applyPush(IN_W'(22), "d_push");
    applyStimulus(2);
    applyRequest("d_dp_in");
    step();
    applyRequest("d_dp_in");
    step();
    step();
    applyRequest("d_drain_zero");
    applyResult(OUT_W'(300));
    checkOutput("d_not_done", 32'(done), 32'd0);
    step();
    checkOutput("d_still_busy", 32'(busy), 32'd1);
    applyResult(OUT_W'(301));
    checkDoneSeq("d");

    // Leftover sample survives into the next run.
    applyStimulus(1);
    applyRequest("r_leftover");
    applyResult(OUT_W'(5));
    checkDoneSeq("r");

    // Full FIFO: ninth push collides with a pop and must be refused.
    applyStimulus(1);
    for (int i = 0; i < 8; i++)
      applyPush(IN_W'(100 + i), "f_push");
    s_valid = 1'b1;
    s_data  = IN_W'(999);
    dp_req  = 4'd1;
    #1;
    checkOutput("f_full_ready", 32'(s_ready), 32'd0);
    checkOutput("f_pop_en", 32'(dp_en), 32'd1);
    step();
    s_valid = 1'b0;
    dp_req  = 4'd0;
    m_issued++;
    checkOutput("f_pop_dp_in", 32'(dp_in), 32'(fifo_q.pop_front()));
    checkOutput("f_ready_again", 32'(s_ready), 32'd1);
    applyResult(OUT_W'(9));
    checkDoneSeq("f");

    // Reset mid-run with three samples still queued.
    applyStimulus(8);
    for (int i = 0; i < 4; i++)
      applyRequest("a_dp_in");
    applyResult(OUT_W'(44));
    step();
    checkOutput("a_queued", 32'(fifo_q.size()), 32'd3);
    done_before = done_seen;
    rst = 1'b1;
    #1;
    checkOutput("a_rst_s_ready", 32'(s_ready), 32'd0);
    checkOutput("a_rst_busy", 32'(busy), 32'd0);
    checkOutput("a_rst_dp_en", 32'(dp_en), 32'd0);
    step();
    checkOutput("a_rst_dp_in", 32'(dp_in), 32'd0);
    checkOutput("a_rst_m_data", 32'(m_data), 32'd0);
    checkOutput("a_rst_m_valid", 32'(m_valid), 32'd0);
    checkOutput("a_rst_done", 32'(done), 32'd0);
    checkOutput("a_rst_stall_cnt", 32'(stall_cnt), 32'd0);
    rst = 1'b0;
    fifo_q.delete();
    #1;
    checkOutput("a_release_s_ready", 32'(s_ready), 32'd1);
    checkOutput("a_release_busy", 32'(busy), 32'd0);
    step();
    step();
    checkOutput("a_no_done_pulse", 32'(done_seen), 32'(done_before));

    // Zero-length run goes straight to DONE.
    applyStimulus(0);
    checkOutput("z_done", 32'(done), 32'd1);
    checkOutput("z_busy", 32'(busy), 32'd1);
    step();
    checkOutput("z_done_drop", 32'(done), 32'd0);
    checkOutput("z_idle", 32'(busy), 32'd0);

    // FIFO was flushed: a request stalls until a fresh sample arrives.
    applyStimulus(1);
    dp_req = 4'd1;
    #1;
    checkOutput("e_flushed_stall", 32'(dp_en), 32'd0);
    applyPush(IN_W'(55), "e_push");
    applyRequest("e_dp_in");
    applyResult(OUT_W'(66));
    checkDoneSeq("e");

    step();
    checkOutput("res_queue_drained", 32'(res_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
